// File: rtl/display_pkg.sv
// Shared defaults and types for the multiplexed seven-segment scan driver.
package display_pkg;
  localparam int NUM_DIGITS_DEF = 8;
  localparam int COUNT_MAX_DEF  = 100000;
  localparam int IDX_W_DEF      = (NUM_DIGITS_DEF > 1) ? $clog2(NUM_DIGITS_DEF) : 1;

  typedef logic [IDX_W_DEF-1:0] digit_idx_t;

  // Wide enough for any practical digit count; users slice to NUM_DIGITS.
  localparam logic [63:0] ANODES_OFF = '1;
endpackage

// File: rtl/refresh_tick_gen.sv
// Refresh prescaler: counts 0..COUNT_MAX-1 and flags the last cycle of each slot.
module refresh_tick_gen
  import display_pkg::*;
#(
  parameter int COUNT_MAX = COUNT_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(COUNT_MAX - 1));

  always_ff @(posedge clk or posedge reset)
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
endmodule

// File: rtl/display_scan_driver.sv
// Multiplexed seven-segment scan driver with per-frame shadow capture.
// Optional leading-zero blanking is compiled in with LEADING_ZERO_BLANK_EN.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int COUNT_MAX  = COUNT_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    freeze,
  output logic [3:0]              BCD_out,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    dp_n
);
  localparam int                    IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0]         LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODES_OFF[NUM_DIGITS-1:0];

  logic                         tick, frame_start, cap;
  logic [IW-1:0]                idx, idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]   shd_val, shd_val_nxt;
  logic [NUM_DIGITS-1:0]        shd_dp, shd_dp_nxt, blank;

  refresh_tick_gen #(.COUNT_MAX(COUNT_MAX)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign frame_start = tick && (idx == LAST);
  assign cap         = frame_start && !freeze;
  assign idx_nxt     = !tick ? idx : (idx == LAST) ? '0 : idx + 1'b1;

  // Output mux looks at the next-state shadow so digit 0 of a new frame
  // already shows the value captured on that same edge.
  assign shd_val_nxt = cap ? value_in : shd_val;
  assign shd_dp_nxt  = cap ? dp_in    : shd_dp;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS:1] hi_zero;
  assign hi_zero[NUM_DIGITS] = 1'b1;
  assign blank[0]            = 1'b0;
  for (genvar i = NUM_DIGITS - 1; i >= 1; i--) begin : g_blank
    if (i == NUM_DIGITS - 1) begin : g_top
      assign hi_zero[i] = (shd_val_nxt[i] == 4'h0);
    end else begin : g_mid
      assign hi_zero[i] = hi_zero[i+1] && (shd_val_nxt[i] == 4'h0);
    end
    assign blank[i] = hi_zero[i] && !shd_dp_nxt[i];
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx     <= '0;
      shd_val <= '0;
      shd_dp  <= '0;
      BCD_out <= 4'h0;
      anodes  <= AN_OFF;
      dp_n    <= 1'b1;
    end else begin
      idx     <= idx_nxt;
      shd_val <= shd_val_nxt;
      shd_dp  <= shd_dp_nxt;
      BCD_out <= shd_val_nxt[idx_nxt];
      anodes  <= blank[idx_nxt] ? AN_OFF : ~(NUM_DIGITS'(1) << idx_nxt);
      dp_n    <= blank[idx_nxt] | ~shd_dp_nxt[idx_nxt];
    end
endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver at COUNT_MAX=4, NUM_DIGITS=8.
module tb_display_scan_driver;
  import display_pkg::*;

  localparam int ND = 8;
  localparam int CM = 4;
  localparam int FR = ND * CM;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] val;
    logic [7:0]  dp;
    logic [7:0]  bmask;  // digits expected dark when blanking is compiled in
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          freeze = 1'b0;
  logic [4*ND-1:0] value_in = '0;
  logic [ND-1:0] dp_in = '0;
  logic [3:0]    BCD_out;
  logic [ND-1:0] anodes;
  logic          dp_n;

  int cyc;
  int passed = 0;
  int total  = 0;
  vec_t vecs[6];

  display_scan_driver #(.NUM_DIGITS(ND), .COUNT_MAX(CM)) dut (
    .clk      (clk),
    .reset    (reset),
    .value_in (value_in),
    .dp_in    (dp_in),
    .freeze   (freeze),
    .BCD_out  (BCD_out),
    .anodes   (anodes),
    .dp_n     (dp_n)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the display slot is floor(cyc/CM) mod ND.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic chk(input string name, input logic [3:0] eb, input logic [7:0] ea, input logic ed);
    total++;
    if (BCD_out === eb && anodes === ea && dp_n === ed) passed++;
    else $display("FAIL %s: got bcd=%h an=%h dp_n=%b, want bcd=%h an=%h dp_n=%b",
                  name, BCD_out, anodes, dp_n, eb, ea, ed);
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc != t && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != t) begin
      total++;
      $display("FAIL wait_cyc: cyc=%0d want=%0d", cyc, t);
    end
  endtask

  task automatic check_frame(input string name, input int f, input int d0, input int d1,
                             input logic [31:0] val, input logic [7:0] dp, input logic [7:0] bm);
    logic [3:0] eb;
    logic [7:0] ea;
    logic       bl, ed;
    for (int i = d0; i <= d1; i++) begin
      wait_cyc(f * FR + i * CM + 2);
      bl = BLANK_ON & bm[i];
      eb = val[4*i +: 4];
      ea = 8'h01 << i;
      ea = bl ? 8'hFF : ~ea;
      ed = bl | ~dp[i];
      chk($sformatf("%s f%0d d%0d", name, f, i), eb, ea, ed);
    end
  endtask

  initial begin
    vecs[0] = '{"scan",    32'h76543210, 8'h00, 8'h00};
    vecs[1] = '{"lz305",   32'h00000305, 8'h00, 8'hF8};
    vecs[2] = '{"dp_zero", 32'h00000000, 8'h04, 8'hFA};
    vecs[3] = '{"zero",    32'h00000000, 8'h00, 8'hFE};
    vecs[4] = '{"dp_ends", 32'hABCDEF01, 8'h81, 8'h00};
    vecs[5] = '{"lz_f5",   32'h00F00000, 8'h00, 8'hC0};

    // Inputs busy during reset must not leak to the outputs.
    repeat (3) @(negedge clk);
    value_in = 32'hFFFFFFFF;
    dp_in    = 8'hFF;
    @(negedge clk);
    chk("reset_hold", 4'h0, 8'hFF, 1'b1);
    value_in = 32'h0;
    dp_in    = 8'h00;
    reset    = 1'b0;

    // Nothing captured until the first frame_start: zeros everywhere.
    check_frame("boot", 0, 0, 7, 32'h0, 8'h00, 8'hFE);

    for (int v = 0; v < 6; v++) begin
      value_in = vecs[v].val;
      dp_in    = vecs[v].dp;
      check_frame(vecs[v].name, v + 1, 0, 7, vecs[v].val, vecs[v].dp, vecs[v].bmask);
    end

    // Mid-frame input change must not tear the frame in progress.
    value_in = 32'h11111111;
    dp_in    = 8'h00;
    check_frame("tear_pre", 7, 0, 2, 32'h11111111, 8'h00, 8'h00);
    value_in = 32'h22222222;
    check_frame("tear_old", 7, 3, 7, 32'h11111111, 8'h00, 8'h00);
    check_frame("tear_new", 8, 0, 7, 32'h22222222, 8'h00, 8'h00);

    // freeze only during the frame_start cycle suppresses that capture.
    wait_cyc(8 * FR + FR - 1);
    value_in = 32'hABCDEF01;
    freeze   = 1'b1;
    wait_cyc(9 * FR);
    freeze   = 1'b0;
    check_frame("frozen",   9,  0, 7, 32'h22222222, 8'h00, 8'h00);
    check_frame("unfrozen", 10, 0, 7, 32'hABCDEF01, 8'h00, 8'h00);

    // Asynchronous reset while digit 5 is active.
    wait_cyc(11 * FR + 5 * CM + 1);
    chk("pre_reset d5", 4'hC, 8'hDF, 1'b1);
    #2 reset = 1'b1;
    #1 chk("reset_async", 4'h0, 8'hFF, 1'b1);
    @(negedge clk);
    chk("reset_held", 4'h0, 8'hFF, 1'b1);
    reset = 1'b0;
    check_frame("post_reset", 0, 0, 7, 32'h0, 8'h00, 8'hFE);
    check_frame("recapture",  1, 0, 7, 32'hABCDEF01, 8'h00, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, meaning the number of multiplexed seven-segment digits.
REQ-002 The block SHALL have parameter COUNT_MAX, default 100000, meaning clock cycles per digit slot (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port value_in, input, 4*NUM_DIGITS bits: nibbles to display; nibble i drives digit i, with digit 0 rightmost.
REQ-006 The block SHALL have port dp_in, input, NUM_DIGITS bits: decimal-point request per digit, active-high.
REQ-007 The block SHALL have port freeze, input, 1 bit: when high, the shadow register is not reloaded.
REQ-008 The block SHALL have port BCD_out, output, 4 bits: the nibble of the active digit, feeding the downstream seven-segment decoder.
REQ-009 The block SHALL have port anodes, output, NUM_DIGITS bits: active-low digit enables.
REQ-010 The block SHALL have port dp_n, output, 1 bit: active-low decimal point of the active digit.

Function
REQ-011 A prescaler SHALL count 0..COUNT_MAX-1 and wrap to 0; tick SHALL be high in the cycle where the count equals COUNT_MAX-1.
REQ-012 Digit index SHALL increment on tick and wrap from NUM_DIGITS-1 to 0.
REQ-013 frame_start SHALL be defined as tick AND index==NUM_DIGITS-1.
REQ-014 On frame_start with freeze low, the shadow registers SHALL capture value_in and dp_in; otherwise they SHALL hold.
REQ-015 Outputs SHALL be registered and show the new index in the cycle after tick.
REQ-016 In that cycle, BCD_out SHALL equal shadow nibble[index], anodes SHALL be all ones except bit[index]=0, and dp_n SHALL equal ~shadow_dp[index].
REQ-017 Exactly one anode bit SHALL be low at any time outside reset, unless the digit is blanked (REQ-023).
REQ-018 Changes on value_in between frame_start events SHALL NOT affect the display, so no frame shows a torn value.
REQ-019 freeze asserted in the same cycle as frame_start SHALL suppress that capture.

Reset
REQ-020 While reset is high, the prescaler SHALL be 0, index 0, shadow value 0, and shadow dp 0.
REQ-021 While reset is high, anodes SHALL be all ones, BCD_out 0, and dp_n 1.
REQ-022 After reset deasserts mid-frame, scanning SHALL restart at digit 0.
REQ-022a The first capture after reset SHALL occur at the first frame_start; the display SHALL show zeros until then.

Configuration
REQ-023 When macro LEADING_ZERO_BLANK_EN is defined, a digit i>0 SHALL be blanked (anode bit high, dp_n 1) if shadow nibbles i..NUM_DIGITS-1 are all zero and shadow_dp[i] is 0.
REQ-024 Digit 0 SHALL never be blanked, so the value 0 displays as a single "0".
REQ-025 When LEADING_ZERO_BLANK_EN is not defined, all digits SHALL be displayed and the blanking logic SHALL be absent.

Structure
REQ-026 A shared package display_pkg SHALL hold the NUM_DIGITS default, the COUNT_MAX default, the digit index typedef (clog2 width), and the ANODES_OFF constant (all ones).
REQ-027 The prescaler SHALL be a sub-module named refresh_tick_gen, with parameter COUNT_MAX, ports clk, reset, and tick.
REQ-028 The remaining logic (index counter, shadow registers, output mux, blanking) SHALL reside in display_scan_driver.

Verification (bench: COUNT_MAX=4, NUM_DIGITS=8)
REQ-029 Scan order: reset released, value_in=32'h76543210 -> after first frame_start, BCD_out steps 0,1,..,7 every 4 cycles; anodes step FE,FD,FB,..,7F; the cycle repeats.
REQ-030 Shadow capture: value_in changed from 32'h11111111 to 32'h22222222 mid-frame -> remaining digits in that frame show 1; the next frame shows 2.
REQ-031 Freeze: freeze=1 across frame_start with value_in=32'hABCDEF01 -> the previous value persists; freeze=0 -> the new value appears from the next frame.
REQ-032 Reset mid-scan: reset pulsed while index=5 -> anodes=FF, BCD_out=0, dp_n=1 immediately (asynchronous); scanning resumes at digit 0.
REQ-033 Blanking (macro on): value_in=32'h00000305 -> anodes of digits 3..7 stay high; digits 0..2 show 5,0,3. With value_in=0, only digit 0 lights and shows 0.
REQ-034 Decimal point: dp_in=8'h04 -> dp_n=0 only while index=2; with the macro on and value_in=0, digit 2 is not blanked.
